// File: rtl/cmp_result_monitor_if.sv
// Bundles the comparator result flags, control strobes and report handshake of cmp_result_monitor.
// The slave modport is the monitor side, and the master modport is the producer/consumer side.
interface cmp_result_monitor_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             A_greater;
  logic             A_equal;
  logic             A_less;
  logic             clear;
  logic             snap_req;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_gt;
  logic [CNT_W-1:0] rpt_eq;
  logic [CNT_W-1:0] rpt_lt;
  logic [CNT_W-1:0] rpt_err;
  logic             illegal;
  logic             stuck_alarm;

  modport master (
    output in_valid, A_greater, A_equal, A_less, clear, snap_req, rpt_ready,
    input  rpt_valid, rpt_gt, rpt_eq, rpt_lt, rpt_err, illegal, stuck_alarm
  );

  modport slave (
    input  in_valid, A_greater, A_equal, A_less, clear, snap_req, rpt_ready,
    output rpt_valid, rpt_gt, rpt_eq, rpt_lt, rpt_err, illegal, stuck_alarm
  );
endinterface

// File: rtl/cmp_result_monitor.sv
// Classifies comparator result flags, keeps saturating per-class counters and reports snapshots.
// Define CMP_MON_STUCK_DETECT_EN to build the stuck-result detector; otherwise stuck_alarm is 0.
module cmp_result_monitor #(
  parameter int CNT_W      = 16,
  parameter int RUN_W      = 8,
  parameter int RUN_THRESH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmp_result_monitor_if.slave  mon
);

  if (RUN_THRESH < 2 || RUN_THRESH > (2**RUN_W) - 1) begin : g_bad_run_thresh
    $error("cmp_result_monitor: RUN_THRESH out of range 2..2^RUN_W-1");
  end

  logic [2:0]       w_flags;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_err;

  logic [CNT_W-1:0] r_cnt_gt;
  logic [CNT_W-1:0] r_cnt_eq;
  logic [CNT_W-1:0] r_cnt_lt;
  logic [CNT_W-1:0] r_cnt_err;

  logic             r_rpt_valid;
  logic [CNT_W-1:0] r_rpt_gt;
  logic [CNT_W-1:0] r_rpt_eq;
  logic [CNT_W-1:0] r_rpt_lt;
  logic [CNT_W-1:0] r_rpt_err;
  logic             r_illegal;
  logic             w_stuck_alarm;

  assign w_flags = {mon.A_greater, mon.A_equal, mon.A_less};

  // Exactly one class strobe is high for every qualified sample.
  always_comb begin
    w_gt  = 1'b0;
    w_eq  = 1'b0;
    w_lt  = 1'b0;
    w_err = 1'b0;
    if (mon.in_valid) begin
      case (w_flags)
        3'b100:  w_gt  = 1'b1;
        3'b010:  w_eq  = 1'b1;
        3'b001:  w_lt  = 1'b1;
        default: w_err = 1'b1;
      endcase
    end
  end

  // clear has priority over any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_gt  <= '0;
      r_cnt_eq  <= '0;
      r_cnt_lt  <= '0;
      r_cnt_err <= '0;
    end else if (mon.clear) begin
      r_cnt_gt  <= '0;
      r_cnt_eq  <= '0;
      r_cnt_lt  <= '0;
      r_cnt_err <= '0;
    end else begin
      if (w_gt  && (r_cnt_gt  != '1)) r_cnt_gt  <= r_cnt_gt  + CNT_W'(1);
      if (w_eq  && (r_cnt_eq  != '1)) r_cnt_eq  <= r_cnt_eq  + CNT_W'(1);
      if (w_lt  && (r_cnt_lt  != '1)) r_cnt_lt  <= r_cnt_lt  + CNT_W'(1);
      if (w_err && (r_cnt_err != '1)) r_cnt_err <= r_cnt_err + CNT_W'(1);
    end
  end

  // Snapshot takes the counter values as they stand before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_valid <= 1'b0;
      r_rpt_gt    <= '0;
      r_rpt_eq    <= '0;
      r_rpt_lt    <= '0;
      r_rpt_err   <= '0;
    end else if (!r_rpt_valid) begin
      if (mon.snap_req) begin
        r_rpt_valid <= 1'b1;
        r_rpt_gt    <= r_cnt_gt;
        r_rpt_eq    <= r_cnt_eq;
        r_rpt_lt    <= r_cnt_lt;
        r_rpt_err   <= r_cnt_err;
      end
    end else if (mon.rpt_ready) begin
      r_rpt_valid <= 1'b0;
    end
  end

  // A sample dropped by clear does not raise illegal either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_err && !mon.clear;
    end
  end

`ifdef CMP_MON_STUCK_DETECT_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_ALARM
  } stuck_state_e;

  localparam logic [RUN_W:0] THRESH = (RUN_W+1)'(RUN_THRESH);

  stuck_state_e     r_state;
  stuck_state_e     w_state_nxt;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_run_nxt;
  logic [1:0]       r_last;
  logic [1:0]       w_last_nxt;
  logic [1:0]       w_code;
  logic [RUN_W:0]   w_run_inc;

  always_comb begin
    w_code = 2'd3;
    case (w_flags)
      3'b100:  w_code = 2'd0;
      3'b010:  w_code = 2'd1;
      3'b001:  w_code = 2'd2;
      default: w_code = 2'd3;
    endcase
  end

  assign w_run_inc = {1'b0, r_run} + (RUN_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_run   <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_last_nxt  = r_last;
    if (mon.clear) begin
      w_state_nxt = ST_IDLE;
      w_run_nxt   = '0;
      w_last_nxt  = '0;
    end else if (mon.in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_err) begin
            w_state_nxt = ST_TRACK;
            w_run_nxt   = RUN_W'(1);
            w_last_nxt  = w_code;
          end
        end
        ST_TRACK: begin
          if (w_err) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
          end else if (w_code == r_last) begin
            w_run_nxt = w_run_inc[RUN_W] ? r_run : w_run_inc[RUN_W-1:0];
            if (w_run_inc == THRESH) w_state_nxt = ST_ALARM;
          end else begin
            w_run_nxt  = RUN_W'(1);
            w_last_nxt = w_code;
          end
        end
        ST_ALARM: begin
          w_state_nxt = ST_ALARM;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  assign w_stuck_alarm = (r_state == ST_ALARM);
`else
  assign w_stuck_alarm = 1'b0;
`endif

  assign mon.rpt_valid   = r_rpt_valid;
  assign mon.rpt_gt      = r_rpt_gt;
  assign mon.rpt_eq      = r_rpt_eq;
  assign mon.rpt_lt      = r_rpt_lt;
  assign mon.rpt_err     = r_rpt_err;
  assign mon.illegal     = r_illegal;
  assign mon.stuck_alarm = w_stuck_alarm;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Directed and random bench for cmp_result_monitor against a run-length/count reference model.
// Counter width is reduced to 4 bits so saturation is reachable quickly.
module tb_cmp_result_monitor;

  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;
  localparam int THRESH = 32;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic clk;
  logic rst_n;

  cmp_result_monitor_if #(.CNT_W(CNT_W)) bus ();

  cmp_result_monitor #(
    .CNT_W      (CNT_W),
    .RUN_W      (8),
    .RUN_THRESH (THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: counts indexed gt/eq/lt/err.
  int m_cnt [4];
  int m_rpt [4];
  bit m_rv;
  bit m_ill;
  bit m_alarm;
  bit m_have;
  int m_last;
  int m_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [2:0] f);
    if (f == GT) return 0;
    if (f == EQ) return 1;
    if (f == LT) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_rpt[k] = 0;
    end
    m_rv = 0; m_ill = 0; m_alarm = 0; m_have = 0; m_last = 0; m_run = 0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] f, input bit clr, input bit snap, input bit rdy);
    int c;
    c = classify(f);
    if (!m_rv && snap) begin
      m_rv = 1;
      for (int k = 0; k < 4; k++) m_rpt[k] = m_cnt[k];
    end else if (m_rv && rdy) begin
      m_rv = 0;
    end
    m_ill = v && !clr && (c == 3);
    if (clr) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else if (v && m_cnt[c] < CMAX) begin
      m_cnt[c]++;
    end
`ifdef CMP_MON_STUCK_DETECT_EN
    if (clr) begin
      m_alarm = 0; m_have = 0; m_run = 0;
    end else if (v && !m_alarm) begin
      if (c == 3) begin
        m_have = 0; m_run = 0;
      end else if (m_have && c == m_last) begin
        m_run++;
        if (m_run >= THRESH) m_alarm = 1;
      end else begin
        m_have = 1; m_last = c; m_run = 1;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    check("rpt_valid",   bus.rpt_valid,   m_rv);
    check("illegal",     bus.illegal,     m_ill);
    check("stuck_alarm", bus.stuck_alarm, m_alarm);
    if (m_rv) begin
      check("rpt_gt",  bus.rpt_gt,  m_rpt[0]);
      check("rpt_eq",  bus.rpt_eq,  m_rpt[1]);
      check("rpt_lt",  bus.rpt_lt,  m_rpt[2]);
      check("rpt_err", bus.rpt_err, m_rpt[3]);
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] f, input bit clr, input bit snap, input bit rdy);
    bus.in_valid  = v;
    bus.A_greater = f[2];
    bus.A_equal   = f[1];
    bus.A_less    = f[0];
    bus.clear     = clr;
    bus.snap_req  = snap;
    bus.rpt_ready = rdy;
  endtask

  task automatic cycle(input bit v, input logic [2:0] f, input bit clr, input bit snap, input bit rdy);
    drive(v, f, clr, snap, rdy);
    @(posedge clk);
    model_edge(v, f, clr, snap, rdy);
    #1;
    check_outputs();
  endtask

  task automatic samples(input int n, input logic [2:0] f);
    for (int k = 0; k < n; k++) cycle(1, f, 0, 0, 0);
  endtask

  task automatic drain();
    cycle(0, 3'b000, 0, 0, 1);
  endtask

  initial begin
    logic [2:0] code;
    logic [2:0] prev;
    bit v, clr, snap, rdy;

    model_reset();
    rst_n = 1'b0;
    drive(0, 3'b000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("reset_rpt_valid", bus.rpt_valid, 0);
    check("reset_rpt_gt", bus.rpt_gt, 0);
    check_outputs();

    // Counts with backpressure
    samples(5, GT);
    samples(3, EQ);
    samples(2, LT);
    samples(1, 3'b110);
    cycle(0, 3'b000, 0, 1, 0);
    check("bp_gt", bus.rpt_gt, 5);
    check("bp_eq", bus.rpt_eq, 3);
    check("bp_lt", bus.rpt_lt, 2);
    check("bp_err", bus.rpt_err, 1);
    repeat (3) cycle(0, 3'b000, 0, 0, 0);
    cycle(0, 3'b000, 0, 0, 1);
    check("bp_valid_after_xfer", bus.rpt_valid, 0);

    // Illegal codes
    cycle(0, 3'b000, 1, 0, 0);
    cycle(1, 3'b000, 0, 0, 0);
    cycle(1, 3'b111, 0, 0, 0);
    check("ill_pulse_111", bus.illegal, 1);
    cycle(0, 3'b000, 0, 1, 0);
    check("ill_single_cycle", bus.illegal, 0);
    check("ill_err_count", bus.rpt_err, 2);
    drain();

    // Stuck alarm
    samples(31, EQ);
    samples(31, LT);
    check("stuck_before_thresh", bus.stuck_alarm, 0);
    samples(1, LT);
`ifdef CMP_MON_STUCK_DETECT_EN
    check("stuck_at_thresh", bus.stuck_alarm, 1);
`endif
    samples(2, GT);
    samples(1, 3'b011);
    samples(3, EQ);
    cycle(0, 3'b000, 1, 0, 0);
    check("stuck_cleared", bus.stuck_alarm, 0);

    // Saturation
    samples(20, GT);
    cycle(0, 3'b000, 0, 1, 0);
    check("sat_gt", bus.rpt_gt, 15);
    drain();

    // Clear collision with sample and snapshot
    cycle(0, 3'b000, 1, 0, 0);
    samples(7, GT);
    cycle(1, GT, 1, 1, 0);
    check("coll_gt", bus.rpt_gt, 7);
    drain();
    cycle(0, 3'b000, 0, 1, 0);
    check("coll_gt_after", bus.rpt_gt, 0);
    drain();

    // Random traffic
    prev = GT;
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom % 40) == 0;
      v    = !clr && (($urandom % 4) != 0);
      snap = ($urandom % 6) == 0;
      rdy  = ($urandom % 2) == 0;
      if (($urandom % 10) < 7) code = prev;
      else code = 3'($urandom % 8);
      prev = code;
      cycle(v, code, clr, snap, rdy);
    end
    drain();

    // Async reset while a report is pending and the alarm is set
    cycle(0, 3'b000, 1, 0, 0);
    samples(32, GT);
    cycle(0, 3'b000, 0, 1, 0);
    check("pre_reset_valid", bus.rpt_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rpt_valid", bus.rpt_valid, 0);
    check("arst_illegal", bus.illegal, 0);
    check("arst_stuck", bus.stuck_alarm, 0);
    check("arst_rpt_gt", bus.rpt_gt, 0);
    check("arst_rpt_eq", bus.rpt_eq, 0);
    check("arst_rpt_lt", bus.rpt_lt, 0);
    check("arst_rpt_err", bus.rpt_err, 0);
    model_reset();
    drive(0, 3'b000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(0, 3'b000, 0, 1, 0);
    check("post_reset_gt", bus.rpt_gt, 0);
    check("post_reset_valid", bus.rpt_valid, 1);
    drain();
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
